// File: rtl/spi_cmd_parser_if.sv
// Byte-stream and register-write bundle between spi_slave, the command parser
// and the synth control plane.
interface spi_cmd_parser_if #(
    parameter int DATA_BYTES = 2
);
    logic                    csn;
    logic [7:0]              byte_in;
    logic                    byte_valid;
    logic                    wr_en;
    logic [3:0]              wr_cmd;
    logic [7:0]              wr_addr;
    logic [DATA_BYTES*8-1:0] wr_data;
    logic                    frame_err;
    logic [7:0]              err_count;
    logic [7:0]              status;

    modport master (
        output csn, byte_in, byte_valid,
        input  wr_en, wr_cmd, wr_addr, wr_data, frame_err, err_count, status
    );

    modport slave (
        input  csn, byte_in, byte_valid,
        output wr_en, wr_cmd, wr_addr, wr_data, frame_err, err_count, status
    );
endinterface

// File: rtl/spi_cmd_parser.sv
// Assembles CMD/ADDR/DATA/CHK byte frames from spi_slave into register-write
// strobes, checking sync nibble and XOR checksum and aborting on csn release.
module spi_cmd_parser #(
    parameter int          DATA_BYTES = 2,
    parameter logic [3:0]  SYNC       = 4'hA
) (
    input  logic               clk,
    input  logic               rstn,
    spi_cmd_parser_if.slave    bus
);
    localparam int         DW       = DATA_BYTES * 8;
    localparam logic [1:0] CNT_INIT = 2'(DATA_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [3:0]      cmd_r, cmd_s;
    logic [7:0]      addr_r, addr_s;
    logic [DW-1:0]   data_r, data_s;
    logic [7:0]      acc_r, acc_s;
    logic [1:0]      cnt_r, cnt_s;
    logic            wr_en_r, wr_en_s;
    logic [3:0]      wr_cmd_r, wr_cmd_s;
    logic [7:0]      wr_addr_r, wr_addr_s;
    logic [DW-1:0]   wr_data_r, wr_data_s;
    logic            frame_err_r, frame_err_s;
    logic            err_inc_s;
    logic [7:0]      err_count_r, err_count_s;
    logic            last_ok_r, last_ok_s;
    logic [7:0]      status_r, status_s;

    // Next-state and next-output logic; abort on csn release outranks any byte.
    always_comb begin
        state_s     = state_r;
        cmd_s       = cmd_r;
        addr_s      = addr_r;
        data_s      = data_r;
        acc_s       = acc_r;
        cnt_s       = cnt_r;
        wr_en_s     = 1'b0;
        wr_cmd_s    = wr_cmd_r;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        frame_err_s = 1'b0;
        err_inc_s   = 1'b0;
        last_ok_s   = last_ok_r;

        if (bus.csn && (state_r != S_IDLE)) begin
            state_s     = S_IDLE;
            acc_s       = 8'h00;
            cnt_s       = 2'd0;
            frame_err_s = 1'b1;
            err_inc_s   = 1'b1;
            last_ok_s   = 1'b0;
        end else if (bus.byte_valid) begin
            case (state_r)
                S_IDLE: begin
                    if (bus.byte_in[7:4] == SYNC) begin
                        cmd_s   = bus.byte_in[3:0];
                        acc_s   = bus.byte_in;
                        state_s = S_ADDR;
                    end else begin
                        err_inc_s = 1'b1;
                    end
                end
                S_ADDR: begin
                    addr_s  = bus.byte_in;
                    acc_s   = acc_r ^ bus.byte_in;
                    cnt_s   = CNT_INIT;
                    state_s = S_DATA;
                end
                S_DATA: begin
                    data_s = DW'({data_r, bus.byte_in});
                    acc_s  = acc_r ^ bus.byte_in;
                    if (cnt_r == 2'd0) begin
                        state_s = S_CHK;
                    end else begin
                        cnt_s = cnt_r - 2'd1;
                    end
                end
                S_CHK: begin
                    state_s = S_IDLE;
                    acc_s   = 8'h00;
                    if (bus.byte_in == acc_r) begin
                        last_ok_s = 1'b1;
                        // cmd 0 is a NOP: acknowledged but never written.
                        if (cmd_r != 4'h0) begin
                            wr_en_s   = 1'b1;
                            wr_cmd_s  = cmd_r;
                            wr_addr_s = addr_r;
                            wr_data_s = data_r;
                        end else begin
                            wr_en_s = 1'b0;
                        end
                    end else begin
                        frame_err_s = 1'b1;
                        err_inc_s   = 1'b1;
                        last_ok_s   = 1'b0;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        if (err_inc_s && (err_count_r != 8'hFF)) begin
            err_count_s = err_count_r + 8'd1;
        end else begin
            err_count_s = err_count_r;
        end

        status_s = {(state_s != S_IDLE), last_ok_s, err_count_s[5:0]};
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= S_IDLE;
            cmd_r       <= 4'h0;
            addr_r      <= 8'h00;
            data_r      <= '0;
            acc_r       <= 8'h00;
            cnt_r       <= 2'd0;
            wr_en_r     <= 1'b0;
            wr_cmd_r    <= 4'h0;
            wr_addr_r   <= 8'h00;
            wr_data_r   <= '0;
            frame_err_r <= 1'b0;
            err_count_r <= 8'h00;
            last_ok_r   <= 1'b0;
            status_r    <= 8'h00;
        end else begin
            state_r     <= state_s;
            cmd_r       <= cmd_s;
            addr_r      <= addr_s;
            data_r      <= data_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            wr_en_r     <= wr_en_s;
            wr_cmd_r    <= wr_cmd_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            frame_err_r <= frame_err_s;
            err_count_r <= err_count_s;
            last_ok_r   <= last_ok_s;
            status_r    <= status_s;
        end
    end

    assign bus.wr_en     = wr_en_r;
    assign bus.wr_cmd    = wr_cmd_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign bus.frame_err = frame_err_r;
    assign bus.err_count = err_count_r;
    assign bus.status    = status_r;
endmodule

// File: tb/tb_spi_cmd_parser.sv
// Self-checking bench for spi_cmd_parser: directed frames plus randomized
// traffic compared against a queue-based frame model.
module tb_spi_cmd_parser;
    localparam int         DB   = 2;
    localparam int         DW   = DB * 8;
    localparam logic [3:0] SYNC = 4'hA;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_parser_if #(.DATA_BYTES(DB)) bus ();

    spi_cmd_parser #(.DATA_BYTES(DB), .SYNC(SYNC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic obs_wr, obs_ferr;
    int   wr_seen   = 0;
    int   ferr_seen = 0;

    // Reference model state
    logic [7:0]    q[$];
    logic [3:0]    exp_cmd;
    logic [7:0]    exp_addr;
    logic [DW-1:0] exp_data;
    logic [7:0]    exp_err;
    logic          exp_last_ok, exp_wr, exp_ferr;
    int            exp_wr_total   = 0;
    int            exp_ferr_total = 0;

    always @(posedge clk) begin
        if (bus.wr_en === 1'b1) wr_seen++;
        if (bus.frame_err === 1'b1) ferr_seen++;
    end

    function automatic void model_reset();
        q.delete();
        exp_cmd = 4'h0; exp_addr = 8'h00; exp_data = '0;
        exp_err = 8'h00; exp_last_ok = 1'b0; exp_wr = 1'b0; exp_ferr = 1'b0;
    endfunction

    function automatic void model_err();
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] x;
        exp_wr = 1'b0; exp_ferr = 1'b0;
        if (q.size() == 0 && b[7:4] != SYNC) begin
            model_err();
            return;
        end
        q.push_back(b);
        if (q.size() == DB + 3) begin
            x = 8'h00;
            for (int i = 0; i < DB + 2; i++) x = x ^ q[i];
            if (x == q[DB+2]) begin
                exp_last_ok = 1'b1;
                if (q[0][3:0] != 4'h0) begin
                    exp_wr = 1'b1; exp_wr_total++;
                    exp_cmd = q[0][3:0]; exp_addr = q[1]; exp_data = '0;
                    for (int i = 0; i < DB; i++) exp_data = (exp_data << 8) | DW'(q[2+i]);
                end
            end else begin
                exp_ferr = 1'b1; exp_ferr_total++;
                model_err(); exp_last_ok = 1'b0;
            end
            q.delete();
        end
    endfunction

    function automatic void model_abort(input logic with_byte, input logic [7:0] b);
        exp_wr = 1'b0; exp_ferr = 1'b0;
        if (q.size() != 0) begin
            exp_ferr = 1'b1; exp_ferr_total++;
            model_err(); exp_last_ok = 1'b0;
            q.delete();
        end else if (with_byte) begin
            model_byte(b);
        end
    endfunction

    function automatic logic [7:0] exp_status();
        return {(q.size() != 0), exp_last_ok, exp_err[5:0]};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); bus.byte_in = b; bus.byte_valid = 1'b1;
        @(negedge clk); bus.byte_valid = 1'b0;
        obs_wr = bus.wr_en; obs_ferr = bus.frame_err;
        repeat (7) @(negedge clk);
        model_byte(b);
    endtask

    task automatic send_frame(input logic [3:0] cmd, input logic [7:0] addr,
                              input logic [DW-1:0] data, input logic corrupt);
        logic [7:0] fb[$];
        logic [7:0] chk;
        fb.push_back({SYNC, cmd});
        fb.push_back(addr);
        for (int i = DB - 1; i >= 0; i--) fb.push_back(data[i*8 +: 8]);
        chk = 8'h00;
        foreach (fb[i]) chk = chk ^ fb[i];
        if (corrupt) chk = chk ^ 8'(8'h01 << $urandom_range(0, 7));
        fb.push_back(chk);
        foreach (fb[i]) send_byte(fb[i]);
    endtask

    task automatic abort(input logic with_byte, input logic [7:0] b);
        @(negedge clk); bus.csn = 1'b1;
        if (with_byte) begin bus.byte_in = b; bus.byte_valid = 1'b1; end
        @(negedge clk); bus.csn = 1'b0; bus.byte_valid = 1'b0;
        obs_wr = bus.wr_en; obs_ferr = bus.frame_err;
        repeat (7) @(negedge clk);
        model_abort(with_byte, b);
    endtask

    task automatic test_reset();
        bus.csn = 1'b0; bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        n_tests++;
        if ({bus.wr_en, bus.frame_err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 00", {bus.wr_en, bus.frame_err});
        end
        n_tests++;
        if ({bus.wr_cmd, bus.wr_addr, bus.wr_data} !== 28'h0) begin
            n_fail++; $display("FAIL reset_wr: got %h expected 0", {bus.wr_cmd, bus.wr_addr, bus.wr_data});
        end
        n_tests++;
        if ({bus.err_count, bus.status} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_err_status: got %h expected 0000", {bus.err_count, bus.status});
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_ok();
        send_frame(4'h3, 8'h10, 16'h1234, 1'b0);
        n_tests++;
        if (obs_wr !== 1'b1 || obs_ferr !== 1'b0) begin
            n_fail++; $display("FAIL ok_strobe: got wr=%b ferr=%b expected wr=1 ferr=0", obs_wr, obs_ferr);
        end
        n_tests++;
        if ({bus.wr_cmd, bus.wr_addr, bus.wr_data} !== {4'h3, 8'h10, 16'h1234}) begin
            n_fail++; $display("FAIL ok_fields: got %h expected 3101234", {bus.wr_cmd, bus.wr_addr, bus.wr_data});
        end
        n_tests++;
        if (bus.status !== 8'h40) begin
            n_fail++; $display("FAIL ok_status: got %h expected 40", bus.status);
        end
    endtask

    task automatic test_bad_chk();
        send_byte(8'hA3); send_byte(8'h10); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        n_tests++;
        if (obs_wr !== 1'b0 || obs_ferr !== 1'b1) begin
            n_fail++; $display("FAIL chk_strobe: got wr=%b ferr=%b expected wr=0 ferr=1", obs_wr, obs_ferr);
        end
        n_tests++;
        if (bus.err_count !== 8'h01 || bus.status !== 8'h01) begin
            n_fail++; $display("FAIL chk_err: got cnt=%h st=%h expected cnt=01 st=01", bus.err_count, bus.status);
        end
        n_tests++;
        if (bus.wr_data !== 16'h1234) begin
            n_fail++; $display("FAIL chk_hold: got %h expected 1234", bus.wr_data);
        end
    endtask

    task automatic test_bad_sync();
        send_byte(8'h5F);
        n_tests++;
        if (obs_ferr !== 1'b0 || bus.err_count !== exp_err) begin
            n_fail++; $display("FAIL sync_drop: got ferr=%b cnt=%h expected ferr=0 cnt=%h", obs_ferr, bus.err_count, exp_err);
        end
        send_frame(4'h5, 8'h22, 16'hBEEF, 1'b0);
        n_tests++;
        if (obs_wr !== 1'b1 || bus.wr_data !== 16'hBEEF || bus.status !== exp_status()) begin
            n_fail++; $display("FAIL sync_next: got wr=%b data=%h st=%h expected wr=1 data=beef st=%h", obs_wr, bus.wr_data, bus.status, exp_status());
        end
    endtask

    task automatic test_abort();
        send_byte(8'hA3); send_byte(8'h10); send_byte(8'h12);
        abort(1'b0, 8'h00);
        n_tests++;
        if (obs_ferr !== 1'b1 || bus.status[7] !== 1'b0 || bus.err_count !== exp_err) begin
            n_fail++; $display("FAIL abort: got ferr=%b st=%h cnt=%h expected ferr=1 busy=0 cnt=%h", obs_ferr, bus.status, bus.err_count, exp_err);
        end
        send_byte(8'hA7); send_byte(8'h33);
        abort(1'b1, 8'h44);
        n_tests++;
        if (obs_ferr !== 1'b1 || bus.status !== exp_status()) begin
            n_fail++; $display("FAIL abort_byte: got ferr=%b st=%h expected ferr=1 st=%h", obs_ferr, bus.status, exp_status());
        end
        send_frame(4'h9, 8'h81, 16'h00FF, 1'b0);
        n_tests++;
        if (obs_wr !== 1'b1 || {bus.wr_cmd, bus.wr_addr, bus.wr_data} !== {4'h9, 8'h81, 16'h00FF}) begin
            n_fail++; $display("FAIL abort_next: got wr=%b f=%h expected wr=1 f=98100ff", obs_wr, {bus.wr_cmd, bus.wr_addr, bus.wr_data});
        end
    endtask

    task automatic test_nop();
        send_frame(4'h0, 8'h55, 16'hCAFE, 1'b0);
        n_tests++;
        if (obs_wr !== 1'b0 || obs_ferr !== 1'b0 || bus.status[6] !== 1'b1) begin
            n_fail++; $display("FAIL nop_strobe: got wr=%b ferr=%b st=%h expected wr=0 ferr=0 last_ok=1", obs_wr, obs_ferr, bus.status);
        end
        n_tests++;
        if ({bus.wr_cmd, bus.wr_addr, bus.wr_data} !== {4'h9, 8'h81, 16'h00FF}) begin
            n_fail++; $display("FAIL nop_hold: got %h expected 98100ff", {bus.wr_cmd, bus.wr_addr, bus.wr_data});
        end
    endtask

    task automatic test_random();
        int r, k;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                send_byte(8'($urandom));
            end else if (r < 25) begin
                k = $urandom_range(1, DB + 2);
                send_byte({SYNC, 4'($urandom)});
                for (int j = 1; j < k; j++) send_byte(8'($urandom));
                abort(1'($urandom), 8'($urandom));
            end else begin
                send_frame(($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
                           8'($urandom), DW'($urandom), ($urandom_range(0, 3) == 0));
            end
            n_tests++;
            if (obs_wr !== exp_wr || obs_ferr !== exp_ferr) begin
                n_fail++; $display("FAIL rnd_strobe[%0d]: got wr=%b ferr=%b expected wr=%b ferr=%b", i, obs_wr, obs_ferr, exp_wr, exp_ferr);
            end
            n_tests++;
            if (bus.err_count !== exp_err || bus.status !== exp_status()) begin
                n_fail++; $display("FAIL rnd_err[%0d]: got cnt=%h st=%h expected cnt=%h st=%h", i, bus.err_count, bus.status, exp_err, exp_status());
            end
            n_tests++;
            if ({bus.wr_cmd, bus.wr_addr, bus.wr_data} !== {exp_cmd, exp_addr, exp_data}) begin
                n_fail++; $display("FAIL rnd_fields[%0d]: got %h expected %h", i, {bus.wr_cmd, bus.wr_addr, bus.wr_data}, {exp_cmd, exp_addr, exp_data});
            end
        end
        n_tests++;
        if (wr_seen != exp_wr_total || ferr_seen != exp_ferr_total) begin
            n_fail++; $display("FAIL pulse_totals: got wr=%0d ferr=%0d expected wr=%0d ferr=%0d", wr_seen, ferr_seen, exp_wr_total, exp_ferr_total);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] b;
        for (int i = 0; i < 300; i++) begin
            b = 8'($urandom);
            if (b[7:4] == SYNC) b[7:4] = 4'h5;
            send_byte(b);
        end
        n_tests++;
        if (bus.err_count !== 8'hFF || exp_err !== 8'hFF) begin
            n_fail++; $display("FAIL saturate: got %h expected ff", bus.err_count);
        end
        n_tests++;
        if (bus.status[5:0] !== 6'h3F || bus.status[7] !== 1'b0) begin
            n_fail++; $display("FAIL sat_status: got %h expected busy=0 low=3f", bus.status);
        end
    endtask

    task automatic test_reset_mid();
        int ferr_before;
        send_byte(8'hA1); send_byte(8'h55); send_byte(8'h66);
        ferr_before = ferr_seen;
        @(negedge clk); rstn = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({bus.wr_en, bus.frame_err, bus.wr_cmd, bus.wr_addr, bus.wr_data, bus.err_count, bus.status} !== 46'h0) begin
            n_fail++; $display("FAIL rst_mid: got %h expected 0", {bus.wr_en, bus.frame_err, bus.wr_cmd, bus.wr_addr, bus.wr_data, bus.err_count, bus.status});
        end
        repeat (2) @(negedge clk); rstn = 1'b1;
        send_frame(4'hC, 8'h3C, 16'h5AA5, 1'b0);
        n_tests++;
        if (obs_wr !== 1'b1 || {bus.wr_cmd, bus.wr_addr, bus.wr_data} !== {4'hC, 8'h3C, 16'h5AA5} || bus.status !== 8'h40) begin
            n_fail++; $display("FAIL rst_next: got wr=%b f=%h st=%h expected wr=1 f=c3c5aa5 st=40", obs_wr, {bus.wr_cmd, bus.wr_addr, bus.wr_data}, bus.status);
        end
        n_tests++;
        if (ferr_seen != ferr_before) begin
            n_fail++; $display("FAIL rst_no_ferr: got %0d expected %0d", ferr_seen, ferr_before);
        end
    endtask

    initial begin
        test_reset();
        test_frame_ok();
        test_bad_chk();
        test_bad_sync();
        test_abort();
        test_nop();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
